nibble_serial_addsub: RTL and testbench
=======================================

// Module: nibble_serial_addsub
// PURPOSE
//  - Multi-cycle two's-complement adder/subtractor; processes WIDTH-bit operands one 4-bit
//    group per clock with a registered inter-group carry (4-bit lookahead per group).
//  - Sits downstream of operand registers; presents results via valid/ready to the result bus.
//  - Area-saving companion to the single-cycle lookahead adder path.
// PARAMETERS
//  - WIDTH  16  operand/result width in bits; must be a multiple of 4, >= 8
// PORTS
//  - clk        in   1      rising-edge clock
//  - rst        in   1      synchronous reset, active-high
//  - in_valid   in   1      operands/op valid
//  - in_ready   out  1      block can accept operands
//  - a          in   WIDTH  operand A
//  - b          in   WIDTH  operand B
//  - sub        in   1      0: A+B, 1: A-B
//  - out_valid  out  1      result valid
//  - out_ready  in   1      consumer accepts result
//  - sum        out  WIDTH  result
//  - cout       out  1      carry out of MSB (for sub: 1 = no borrow)
//  - ovf        out  1      signed overflow
// BEHAVIOUR
//  - Reset: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, group counter=0.
//  - N = WIDTH/4. States: IDLE -> BUSY -> DONE -> IDLE.
//  - IDLE: in_ready=1. Edge with in_valid&in_ready: latch a, b^{WIDTH{sub}}, a[MSB]; set
//    carry reg = sub; counter=0; -> BUSY. in_valid without handshake: no effect.
//  - BUSY: in_ready=0. Each edge: group k (counter) = a[4k+3:4k] + b'[4k+3:4k] + carry,
//    using p=a^b', g=a&b' and 4-bit lookahead carries; write sum nibble k; carry reg <= c[3];
//    counter++. On the edge processing group N-1 (c3 = group carry-out, c2 = carry into MSB):
//    cout<=c3, ovf<=c3^c2; -> DONE.
//  - Latency: out_valid rises exactly N edges after the accept edge; throughput 1 op per N+2 cycles.
//  - DONE: out_valid=1; sum/cout/ovf stable until out_ready=1; on that edge -> IDLE,
//    out_valid<=0. No same-cycle new accept (in_ready is 0 in DONE).
//  - out_ready in IDLE/BUSY ignored. in_valid/operand changes during BUSY/DONE ignored.
//  - sum holds its last value in IDLE (not cleared); only out_valid qualifies it.
//  - rst at any state (incl. mid-BUSY) overrides: returns to reset values next edge; the
//    in-flight operation is discarded, no result emitted.
//  - All arithmetic modulo 2^WIDTH; ovf per signed interpretation of a, b, sum.
// CONFIGURATION
//  - NSA_SATURATE_EN defined: on DONE entry with ovf=1, sum <= latched a[MSB] ? {1,0..0}
//    (most negative) : {0,1..1} (most positive); ovf still reports 1; cout unchanged.
//  - Not defined: sum is the wrapped result; no saturation logic present.
// TESTING (WIDTH=16)
//  - 0x00FF+0x0001, sub=0 -> sum=0x0100, cout=0, ovf=0; out_valid exactly 4 edges after accept.
//  - 0x7FFF+0x0001 -> sum=0x8000, ovf=1, cout=0; with NSA_SATURATE_EN sum=0x7FFF.
//  - 0x0000-0x0001 (sub=1) -> sum=0xFFFF, cout=0, ovf=0; 0x0005-0x0003 -> 0x0002, cout=1.
//  - 0x8000-0x0001 -> sum=0x7FFF, ovf=1, cout=1; with NSA_SATURATE_EN sum=0x8000.
//  - out_ready low 3 cycles in DONE -> out_valid/sum/cout/ovf held, in_ready=0; in_valid pulses ignored.
//  - rst at 2nd BUSY cycle -> next edge in_ready=1, out_valid=0, sum=0; new op 0x1234+0x1111 -> 0x2345.

Source files
------------

// File: rtl/nibble_serial_addsub_if.sv
// nibble_serial_addsub_if: operand handshake and result bus for the nibble-serial adder/subtractor.
interface nibble_serial_addsub_if #(parameter int WIDTH = 16);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   modport master (output in_valid, a, b, sub, out_ready,
                   input  in_ready, out_valid, sum, cout, ovf);
   modport slave  (input  in_valid, a, b, sub, out_ready,
                   output in_ready, out_valid, sum, cout, ovf);
endinterface

// File: rtl/nibble_serial_addsub.sv
// nibble_serial_addsub: multi-cycle adder/subtractor, one 4-bit lookahead group per clock.
// Define NSA_SATURATE_EN to clamp overflowing results to the most positive/negative value.
module nibble_serial_addsub #(
   parameter int WIDTH = 16
) (
   input logic clk,
   input logic rst,
   nibble_serial_addsub_if.slave bus
);
   localparam int N  = WIDTH / 4;
   localparam int CW = $clog2(N);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t           state;
   logic [WIDTH-1:0] ar, br, sum_r;
   logic [CW-1:0]    cnt;
   logic             carry, in_ready_r, out_valid_r, cout_r, ovf_r;
`ifdef NSA_SATURATE_EN
   logic             a_msb;
`endif
   logic [3:0]       an, bn, p, g, c, s;
   assign an = ar[4*cnt +: 4];
   assign bn = br[4*cnt +: 4];
   assign p  = an ^ bn;
   assign g  = an & bn;
   assign c[0] = g[0] | (p[0] & carry);
   assign c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
   assign c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry);
   assign c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (&p & carry);
   assign s  = p ^ {c[2:0], carry};
   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.sum       = sum_r;
   assign bus.cout      = cout_r;
   assign bus.ovf       = ovf_r;
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         sum_r       <= '0;
         cout_r      <= 1'b0;
         ovf_r       <= 1'b0;
         cnt         <= '0;
         carry       <= 1'b0;
         ar          <= '0;
         br          <= '0;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               ar         <= bus.a;
               br         <= bus.b ^ {WIDTH{bus.sub}};
               carry      <= bus.sub;
               cnt        <= '0;
               in_ready_r <= 1'b0;
               state      <= BUSY;
`ifdef NSA_SATURATE_EN
               a_msb      <= bus.a[WIDTH-1];
`endif
            end
            BUSY: begin
               sum_r[4*cnt +: 4] <= s;
               carry             <= c[3];
               cnt               <= cnt + 1'b1;
               if (cnt == CW'(N-1)) begin
                  cout_r      <= c[3];
                  ovf_r       <= c[3] ^ c[2];
                  out_valid_r <= 1'b1;
                  state       <= DONE;
`ifdef NSA_SATURATE_EN
                  // later NBA overrides the nibble write above when clamping
                  if (c[3] ^ c[2])
                     sum_r <= a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
               end
            end
            DONE: if (bus.out_ready) begin
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b1;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_nibble_serial_addsub.sv
// tb_nibble_serial_addsub: directed and random checks against an arithmetic reference model.
module tb_nibble_serial_addsub;
   localparam int W = 16;
   localparam int N = W / 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;
   nibble_serial_addsub_if #(.WIDTH(W)) bus ();
   nibble_serial_addsub #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        output logic [W-1:0] s, output logic co, output logic ov);
      logic [W:0] full;
      full = sub ? ({1'b0, a} + {1'b0, ~b} + 1) : ({1'b0, a} + {1'b0, b});
      s  = full[W-1:0];
      co = full[W];
      ov = sub ? (a[W-1] != b[W-1] && s[W-1] != a[W-1]) : (a[W-1] == b[W-1] && s[W-1] != a[W-1]);
`ifdef NSA_SATURATE_EN
      if (ov) s = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      int guard;
      guard = 0;
      while (bus.in_ready !== 1'b1 && guard < 20) begin
         tick();
         guard++;
      end
      check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.a = a;
      bus.b = b;
      bus.sub = sub;
      tick();
      bus.in_valid = 1'b0;
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      bus.sub = 1'($urandom);
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input int hold);
      logic [W-1:0] es;
      logic eco, eov;
      int lat;
      model(a, b, sub, es, eco, eov);
      accept(a, b, sub);
      check({tag, "_in_ready_busy"}, 32'(bus.in_ready), 32'd0);
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < 20) begin
         tick();
         if (bus.out_valid !== 1'b1) lat++;
      end
      check({tag, "_latency"}, lat, N);
      check({tag, "_sum"}, 32'(bus.sum), 32'(es));
      check({tag, "_cout"}, 32'(bus.cout), 32'(eco));
      check({tag, "_ovf"}, 32'(bus.ovf), 32'(eov));
      for (int i = 0; i < hold; i++) begin
         bus.in_valid = 1'($urandom);
         tick();
         check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
         check({tag, "_hold_ready"}, 32'(bus.in_ready), 32'd0);
         check({tag, "_hold_sum"}, {bus.sum, 14'd0, bus.cout, bus.ovf}, {es, 14'd0, eco, eov});
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check({tag, "_release_valid"}, 32'(bus.out_valid), 32'd0);
      check({tag, "_release_ready"}, 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.sub = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("reset_state", {bus.sum, 12'd0, bus.in_ready, bus.out_valid, bus.cout, bus.ovf},
            {16'h0000, 12'd0, 4'b1000});
      run_op("carry_chain", 16'h00FF, 16'h0001, 1'b0, 0);
      run_op("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 0);
      run_op("borrow", 16'h0000, 16'h0001, 1'b1, 0);
      run_op("sub_small", 16'h0005, 16'h0003, 1'b1, 3);
      run_op("neg_ovf", 16'h8000, 16'h0001, 1'b1, 0);
      run_op("all_ones", 16'hFFFF, 16'hFFFF, 1'b0, 0);
      // mid-operation reset must discard the result and clear sum
      accept(16'hABCD, 16'h1111, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_mid_busy", {bus.sum, 14'd0, bus.in_ready, bus.out_valid}, {16'h0000, 14'd0, 2'b10});
      tick();
      check("rst_no_result", 32'(bus.out_valid), 32'd0);
      run_op("after_rst", 16'h1234, 16'h1111, 1'b0, 0);
      for (int i = 0; i < 20; i++)
         run_op("random", W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
